// File: rtl/mc_control_if.sv
// Datapath <-> multicycle control bus. slave = mc_control, master = datapath side.
interface mc_control_if;
  logic [3:0] i_opcode;
  logic       i_mem_ready;
  logic       i_zero;
  logic [1:0] o_alu_op;
  logic       o_alu_src;
  logic       o_pc_write;
  logic       o_ir_write;
  logic       o_mem_read;
  logic       o_mem_write;
  logic       o_reg_write;
  logic       o_mem_to_reg;
  logic [1:0] o_pc_src;
  logic [2:0] o_state;
  logic       o_illegal;
  logic       o_bus_error;
  logic       o_halted;

  modport master (
    output i_opcode, i_mem_ready, i_zero,
    input  o_alu_op, o_alu_src, o_pc_write, o_ir_write, o_mem_read, o_mem_write,
           o_reg_write, o_mem_to_reg, o_pc_src, o_state, o_illegal, o_bus_error, o_halted
  );

  modport slave (
    input  i_opcode, i_mem_ready, i_zero,
    output o_alu_op, o_alu_src, o_pc_write, o_ir_write, o_mem_read, o_mem_write,
           o_reg_write, o_mem_to_reg, o_pc_src, o_state, o_illegal, o_bus_error, o_halted
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define MEM_WAIT_TIMEOUT_EN to bound memory waits and raise bus_error on expiry.
module mc_control #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        i_clock,
  input  logic        i_reset,
  mc_control_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_opcode;

  logic [1:0] w_alu_op;
  logic       w_alu_src;
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_mem_to_reg;
  logic [1:0] w_pc_src;
  logic       w_illegal;
  logic       w_halted;
  logic       w_timeout;
  logic       w_bus_error;

  // Opcode is captured on the same edge the IR loads, so it stays valid through WB.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state  <= S_FETCH;
      r_opcode <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && bus.i_mem_ready)
        r_opcode <= bus.i_opcode;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_alu_op     = 2'b00;
    w_alu_src    = 1'b0;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_pc_src     = 2'b00;
    w_illegal    = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = bus.i_mem_ready;
        w_pc_write = bus.i_mem_ready;
        if (bus.i_mem_ready) w_next = S_DECODE;
        else if (w_timeout)  w_next = S_HALT;
      end
      S_DECODE: begin
        case (r_opcode)
          OP_HALT: w_next = S_HALT;
          OP_JMP: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'b10;
            w_next     = S_FETCH;
          end
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: w_next = S_EXEC;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        case (r_opcode)
          OP_R: begin
            w_alu_op = 2'b10;
            w_next   = S_WB;
          end
          OP_ADDI: begin
            w_alu_src = 1'b1;
            w_next    = S_WB;
          end
          OP_LW, OP_SW: begin
            w_alu_src = 1'b1;
            w_next    = S_MEM;
          end
          OP_BEQ: begin
            w_alu_op   = 2'b01;
            w_pc_src   = 2'b01;
            w_pc_write = bus.i_zero;
            w_next     = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_mem_read  = (r_opcode == OP_LW);
        w_mem_write = (r_opcode == OP_SW);
        if (bus.i_mem_ready) w_next = (r_opcode == OP_LW) ? S_WB : S_FETCH;
        else if (w_timeout)  w_next = S_HALT;
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (r_opcode == OP_LW);
        w_next       = S_FETCH;
      end
      S_HALT: w_halted = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

`ifdef MEM_WAIT_TIMEOUT_EN
  localparam int              CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LIM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_wait_cnt;
  logic          r_bus_error;
  logic          w_waiting;

  assign w_waiting = (r_state == S_FETCH || r_state == S_MEM) && !bus.i_mem_ready;
  // Fires on the wait cycle whose increment would reach the limit.
  assign w_timeout   = w_waiting && (r_wait_cnt >= LIM);
  assign w_bus_error = r_bus_error;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_timeout) r_bus_error <= 1'b1;
      if (!w_waiting || w_next != r_state) r_wait_cnt <= '0;
      else                                 r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign w_bus_error = 1'b0;
`endif

  // Everything is masked during reset so no strobe escapes while the FSM is held.
  assign bus.o_alu_op     = i_reset ? w_alu_op : 2'b00;
  assign bus.o_alu_src    = i_reset & w_alu_src;
  assign bus.o_pc_write   = i_reset & w_pc_write;
  assign bus.o_ir_write   = i_reset & w_ir_write;
  assign bus.o_mem_read   = i_reset & w_mem_read;
  assign bus.o_mem_write  = i_reset & w_mem_write;
  assign bus.o_reg_write  = i_reset & w_reg_write;
  assign bus.o_mem_to_reg = i_reset & w_mem_to_reg;
  assign bus.o_pc_src     = i_reset ? w_pc_src : 2'b00;
  assign bus.o_state      = i_reset ? r_state : 3'd0;
  assign bus.o_illegal    = i_reset & w_illegal;
  assign bus.o_bus_error  = i_reset & w_bus_error;
  assign bus.o_halted     = i_reset & w_halted;

endmodule

// File: tb/tb_mc_control.sv
// Table-driven check of mc_control: one row per clock, outputs sampled before the rising edge.
module tb_mc_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control #(.TIMEOUT_CYCLES(15)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        mr;
    logic        z;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nchk = 0;
  int   nerr = 0;

  logic [16:0] act;
  assign act = {bus.o_state, bus.o_alu_op, bus.o_alu_src, bus.o_pc_write, bus.o_ir_write,
                bus.o_mem_read, bus.o_mem_write, bus.o_reg_write, bus.o_mem_to_reg,
                bus.o_pc_src, bus.o_illegal, bus.o_bus_error, bus.o_halted};

  // {state, alu_op, alu_src, pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, pc_src, illegal, bus_error, halted}
  function automatic logic [16:0] e(input logic [2:0] st, input logic [1:0] aop, input logic asrc,
                                    input logic pcw, input logic irw, input logic mrd, input logic mwr,
                                    input logic rw, input logic m2r, input logic [1:0] pcs,
                                    input logic ill, input logic be, input logic h);
    return {st, aop, asrc, pcw, irw, mrd, mwr, rw, m2r, pcs, ill, be, h};
  endfunction

  function automatic logic [16:0] x_zero();     return '0; endfunction
  function automatic logic [16:0] x_fetch(input logic rdy);
    return e(3'd0, 2'b00, 1'b0, rdy, rdy, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] x_decode();
    return e(3'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] x_halt(input logic be);
    return e(3'd5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, be, 1'b1);
  endfunction

  function automatic void add(input logic rst, input logic [3:0] op, input logic mr,
                              input logic z, input logic [16:0] exp);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.z = z; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    rst_n           = v.rst;
    bus.i_opcode    = v.op;
    bus.i_mem_ready = v.mr;
    bus.i_zero      = v.z;
    #1;
    nchk++;
    if (act !== v.exp) begin
      nerr++;
      $display("FAIL %s: got %05h expected %05h", name, act, v.exp);
    end
  endtask

  initial begin
    bus.i_opcode    = 4'b0000;
    bus.i_mem_ready = 1'b0;
    bus.i_zero      = 1'b0;

    // Reset two cycles: everything zero
    add(0, 4'h0, 1, 0, x_zero());
    add(0, 4'h0, 1, 0, x_zero());
    // R-type: 0,1,2,4
    add(1, 4'h0, 1, 0, x_fetch(1));
    add(1, 4'h0, 1, 0, x_decode());
    add(1, 4'h0, 1, 0, e(3'd2, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    add(1, 4'h0, 1, 0, e(3'd4, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0));
    // LW with three MEM wait cycles; opcode input changes after fetch and must be ignored
    add(1, 4'h2, 1, 0, x_fetch(1));
    add(1, 4'hF, 1, 0, x_decode());
    add(1, 4'hF, 1, 0, e(3'd2, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    add(1, 4'hF, 0, 0, e(3'd3, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    add(1, 4'hF, 0, 0, e(3'd3, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    add(1, 4'hF, 0, 0, e(3'd3, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    add(1, 4'hF, 1, 0, e(3'd3, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    add(1, 4'hF, 1, 0, e(3'd4, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0));
    // BEQ taken
    add(1, 4'h4, 1, 1, x_fetch(1));
    add(1, 4'h4, 1, 1, x_decode());
    add(1, 4'h4, 1, 1, e(3'd2, 2'b01, 0, 1, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0));
    // BEQ not taken
    add(1, 4'h4, 1, 0, x_fetch(1));
    add(1, 4'h4, 1, 0, x_decode());
    add(1, 4'h4, 1, 0, e(3'd2, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0));
    // SW
    add(1, 4'h3, 1, 0, x_fetch(1));
    add(1, 4'h3, 1, 0, x_decode());
    add(1, 4'h3, 1, 0, e(3'd2, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    add(1, 4'h3, 1, 0, e(3'd3, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
    // JMP after one fetch wait
    add(1, 4'h5, 0, 0, x_fetch(0));
    add(1, 4'h5, 1, 0, x_fetch(1));
    add(1, 4'h5, 1, 0, e(3'd1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0));
    // Illegal 0111 pulses once, then HALT
    add(1, 4'h7, 1, 0, x_fetch(1));
    add(1, 4'h7, 1, 0, e(3'd1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    add(1, 4'hF, 1, 0, x_fetch(1));
    add(1, 4'hF, 1, 0, x_decode());
    for (int i = 0; i < 10; i++) add(1, 4'(i), 1, 0, x_halt(0));
    // Reset out of HALT, then abort an R-type in EXEC
    add(0, 4'h0, 1, 0, x_zero());
    add(1, 4'h0, 1, 0, x_fetch(1));
    add(1, 4'h0, 1, 0, x_decode());
    add(1, 4'h0, 1, 0, e(3'd2, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    add(0, 4'h0, 1, 0, x_zero());
    add(1, 4'h0, 0, 0, x_fetch(0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec[%0d]", i));

    // Long FETCH wait: bounded only when the timeout feature is built in
    tbl.delete();
    add(0, 4'h0, 0, 0, x_zero());
`ifdef MEM_WAIT_TIMEOUT_EN
    for (int i = 0; i < 15; i++) add(1, 4'h0, 0, 0, x_fetch(0));
    add(1, 4'h0, 0, 0, x_halt(1));
    add(1, 4'h0, 1, 0, x_halt(1));
    add(0, 4'h0, 1, 0, x_zero());
    add(1, 4'h0, 1, 0, x_fetch(1));
`else
    for (int i = 0; i < 20; i++) add(1, 4'h0, 0, 0, x_fetch(0));
    add(1, 4'h0, 1, 0, x_fetch(1));
    add(1, 4'h0, 1, 0, x_decode());
`endif
    foreach (tbl[i]) apply(tbl[i], $sformatf("wait[%0d]", i));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
